// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default operand width.
package muldiv_pkg;

   localparam int unsigned WidthDefault = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StFix
   } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO. It runs one multiply or divide
// bit per cycle, then applies a sign fix before the result is written to HI/LO.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = WidthDefault
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wd,
   input  logic             rd_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic             stall
);

   localparam int unsigned CntW = $clog2(WIDTH);

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 sgn_q, sgn_d;
   logic                 neg_q, neg_d;
   logic                 sa_q, sa_d;
   logic                 divz_q, divz_d;
   logic                 is_div_q, is_div_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     orig_a_q, orig_a_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 dbz_q, dbz_d;

   logic                 st_sa, st_sb;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift, div_trial;
   logic [2*WIDTH-1:0]   prod;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sgn_d     = sgn_q;
      neg_d     = neg_q;
      sa_d      = sa_q;
      divz_d    = divz_q;
      is_div_d  = is_div_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      rem_d     = rem_q;
      orig_a_d  = orig_a_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      st_sa     = ~op[0] & a[WIDTH-1];
      st_sb     = ~op[0] & b[WIDTH-1];
      abs_a     = st_sa ? -a : a;
      abs_b     = st_sb ? -b : b;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
      // Trial subtract needs WIDTH+1 bits: the shifted partial remainder can exceed WIDTH bits.
      div_shift = {rem_q, acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opb_q};
      prod      = (sgn_q & neg_q) ? -acc_q : acc_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sgn_d    = ~op[0];
               sa_d     = st_sa;
               neg_d    = st_sa ^ st_sb;
               is_div_d = op[1];
               divz_d   = op[1] & (b == '0);
               orig_a_d = a;
               cnt_d    = '0;
               rem_d    = '0;
               dbz_d    = 1'b0;
               if (op[1]) begin
                  acc_d   = {{WIDTH{1'b0}}, abs_a};
                  opb_d   = abs_b;
                  state_d = StDiv;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, abs_b};
                  opb_d   = abs_a;
                  state_d = StMul;
               end
            end else begin
               if (hi_we) hi_d = wd;
               if (lo_we) lo_d = wd;
            end
         end
         StMul: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
         end
         StDiv: begin
            if (!div_trial[WIDTH]) begin
               rem_d = div_trial[WIDTH-1:0];
               acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = div_shift[WIDTH-1:0];
               acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
         end
         StFix: begin
            if (!is_div_q) begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (divz_q) begin
               hi_d  = orig_a_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               lo_d = (sgn_q & neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = (sgn_q & sa_q) ? -rem_q : rem_q;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sgn_q    <= 1'b0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         divz_q   <= 1'b0;
         is_div_q <= 1'b0;
         acc_q    <= '0;
         opb_q    <= '0;
         rem_q    <= '0;
         orig_a_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sgn_q    <= sgn_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         divz_q   <= divz_d;
         is_div_q <= is_div_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         rem_q    <= rem_d;
         orig_a_q <= orig_a_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state_q != StIdle);
   assign done  = done_q;
   assign dbz   = dbz_q;
   assign stall = busy & (rd_req | start | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of operations with hand-computed
// HI/LO, plus sequences for stall behaviour, idle MTHI/MTLO and mid-operation reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b, wd;
   logic        hi_we, lo_we, rd_req;
   logic [31:0] hi, lo;
   logic        busy, done, dbz, stall;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
   } vec_t;

   vec_t vecs[8];

   muldiv_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .wd     (wd),
      .rd_req (rd_req),
      .hi     (hi),
      .lo     (lo),
      .busy   (busy),
      .done   (done),
      .dbz    (dbz),
      .stall  (stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Launch in cycle 0, return at the negedge of the cycle where done is seen.
   task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         output int lat, output int busy_cyc);
      @(negedge clk);
      start = 1'b1; op = o; a = aa; b = bb;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      busy_cyc = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n > 1) @(negedge clk);
         if (done) begin
            lat = n;
            break;
         end
         if (busy) busy_cyc++;
      end
   endtask

   initial begin
      int lat, bc;

      vecs[0] = '{"mult_neg3x7", OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1] = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[2] = '{"div_neg7_2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3] = '{"divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[4] = '{"divu_by0",    OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
      vecs[5] = '{"div_7_neg2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
      vecs[6] = '{"div_neg5_by0",OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
      vecs[7] = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; wd = '0;
      hi_we = 1'b0; lo_we = 1'b0; rd_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_dbz", 64'(dbz), 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
         chk({vecs[i].name, "_latency"}, 64'(lat), 64'd34);
         chk({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd33);
         chk({vecs[i].name, "_busy_at_done"}, 64'(busy), 64'd0);
         chk({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
         chk({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
         chk({vecs[i].name, "_dbz"}, 64'(dbz), 64'(vecs[i].exp_dbz));
         rd_req = 1'b1;
         #1 chk({vecs[i].name, "_rd_stall"}, 64'(stall), 64'd0);
         rd_req = 1'b0;
         @(negedge clk);
         chk({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
      end

      // MULT 5x6 with rd_req, start and lo_we presented while busy.
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n > 1) @(negedge clk);
         rd_req = 1'b0; start = 1'b0; lo_we = 1'b0;
         if (n == 5) begin
            rd_req = 1'b1;
            #1 chk("busy_rd_stall", 64'(stall), 64'd1);
         end
         if (n == 6) begin
            start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
            #1 chk("busy_start_stall", 64'(stall), 64'd1);
         end
         if (n == 7) begin
            lo_we = 1'b1; wd = 32'hAA;
            #1 chk("busy_lowe_stall", 64'(stall), 64'd1);
         end
         if (done) begin
            lat = n;
            break;
         end
      end
      chk("mul5x6_latency", 64'(lat), 64'd34);
      chk("mul5x6_hi", 64'(hi), 64'd0);
      chk("mul5x6_lo", 64'(lo), 64'd30);
      @(negedge clk);
      chk("no_second_op", 64'(busy), 64'd0);

      // Idle MTLO / MTHI.
      lo_we = 1'b1; wd = 32'hAA;
      #1 chk("idle_lowe_stall", 64'(stall), 64'd0);
      @(negedge clk);
      lo_we = 1'b0;
      chk("idle_lowe_lo", 64'(lo), 64'hAA);
      hi_we = 1'b1; wd = 32'h55;
      @(negedge clk);
      hi_we = 1'b0;
      chk("idle_hiwe_hi", 64'(hi), 64'h55);
      chk("idle_hiwe_lo_kept", 64'(lo), 64'hAA);

      // Reset during a DIV discards the operation.
      start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_reset_busy", 64'(busy), 64'd0);
      chk("mid_reset_hi", 64'(hi), 64'd0);
      chk("mid_reset_lo", 64'(lo), 64'd0);
      chk("mid_reset_done", 64'(done), 64'd0);

      run_op(OP_MULTU, 32'd3, 32'd4, lat, bc);
      chk("post_reset_latency", 64'(lat), 64'd34);
      chk("post_reset_hi", 64'(hi), 64'd0);
      chk("post_reset_lo", 64'(lo), 64'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit that owns the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over multiple cycles beside the single-cycle ALU. It serves MFHI/MFLO reads and MTHI/MTLO writes, and raises a stall toward the PC/register-file write enable while a HI/LO access must wait for an in-flight operation.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  launch an operation (decoded MULT/MULTU/DIV/DIVU)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- hi_we  in  1  MTHI: write wd into HI
- lo_we  in  1  MTLO: write wd into LO
- wd  in  WIDTH  MTHI/MTLO data
- rd_req  in  1  current instruction is MFHI or MFLO
- hi  out  WIDTH  HI register, reset 0
- lo  out  WIDTH  LO register, reset 0
- busy  out  1  operation in flight, reset 0
- done  out  1  one-cycle pulse, HI/LO just updated by an operation, reset 0
- dbz  out  1  last completed divide had b==0; held until next start, reset 0
- stall  out  1  combinational: busy & (rd_req | start | hi_we | lo_we), reset 0

## Operation
- States: IDLE, MUL, DIV, FIX. Reset forces IDLE, clears HI, LO, dbz, count and working registers.
- IDLE, start=1: latch op signedness and sign bits. Latch |a| and |b| for signed ops, raw values for unsigned. Count=0. Go to MUL (op[1]=0) or DIV (op[1]=1). Clear dbz.
- IDLE, start=0: hi_we writes HI, lo_we writes LO (both may fire together). start has priority; hi_we/lo_we in the same cycle as an accepted start are ignored.
- MUL: radix-2 shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle. After WIDTH cycles go to FIX.
- DIV: restoring division on WIDTH-bit magnitudes, one quotient bit per cycle. Remainder register is WIDTH+1 bits for the trial subtract. After WIDTH cycles go to FIX.
- FIX, signed multiply: negate the 2*WIDTH product if the operand signs differ.
- FIX, signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- FIX, all ops: write {HI,LO} = {product high, product low}, or {remainder, quotient}. Pulse done. Return to IDLE.
- Divide by zero (b==0, signed or unsigned): LO = all ones, HI = original a, dbz=1. The sign fix is skipped.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no flag).
- start, hi_we and lo_we while busy: ignored. The stall output holds the pipeline so the instruction re-presents after completion.
- HI/LO change only on an IDLE write or on the FIX edge. Partial results are never visible.
- reset mid-operation: the next cycle shows IDLE, busy=0, done=0, HI=LO=0. The in-flight result is discarded.

## Timing
- Cycle 0: start=1 in IDLE, accepted on the closing edge.
- Cycles 1..32: busy=1, one iteration per edge.
- Cycle 33: busy=1, state FIX.
- Cycle 34: busy=0, done=1, new HI/LO visible. A new start is accepted in cycle 34.
- Total latency is WIDTH+2 edges from the start edge to result visibility.
- rd_req in cycle 34 reads the new value with stall=0.
- stall is purely combinational from inputs and busy; it has no registered delay.
- MTHI/MTLO in IDLE: the value is visible on hi/lo the cycle after the write edge.

## Structure
- Shared package muldiv_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, MUL, DIV, FIX);
  - the default WIDTH.
- The main decoder imports the op constants to drive op.
- No sub-module: the multiply step, divide step and sign fix are small enough to sit inline.
- The shared async-reset dff is not used, because this block's reset is synchronous.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, done=1 exactly one cycle, busy=1 cycles 1..33.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234, dbz=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, dbz=0.
- During MULT 5x6, in cycle 5: assert rd_req, then start (op DIVU), then lo_we with wd=0xAA in separate cycles.
  - Response: stall=1 each cycle; HI=0, LO=30 at cycle 34 unaffected.
  - In idle, lo_we wd=0xAA -> LO=0xAA next cycle, stall=0.
- reset asserted in cycle 10 of a DIV -> cycle 11: busy=0, HI=LO=0, done=0.
  - A following MULTU 3x4 gives LO=12 after WIDTH+2 edges.
